// File: rtl/attack_pattern_scheduler.sv
// Enemy-turn sequencer: PICK -> WARN -> ACTIVE (timed spawns) -> COOLDOWN.
// Optional macro ATTACK_REPEAT_GUARD_EN avoids picking the same pattern twice in a row.
module attack_pattern_scheduler #(
    parameter int TICK_DIV       = 833333,
    parameter int WARN_TICKS     = 30,
    parameter int ATTACK_TICKS   = 240,
    parameter int SPAWN_PERIOD   = 20,
    parameter int COOLDOWN_TICKS = 60
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [1:0] random_num,
    input  logic       start,
    input  logic       abort,
    output logic [1:0] pattern,
    output logic       warn,
    output logic       active,
    output logic       spawn,
    output logic [1:0] spawn_lane,
    output logic       busy,
    output logic       turn_done
);

    localparam int MAXT_A = (WARN_TICKS > ATTACK_TICKS) ? WARN_TICKS : ATTACK_TICKS;
    localparam int MAXT   = (MAXT_A > COOLDOWN_TICKS) ? MAXT_A : COOLDOWN_TICKS;
    localparam int CW     = $clog2(TICK_DIV);
    localparam int TW     = (MAXT > 0) ? $clog2(MAXT + 1) : 1;
    localparam int SW     = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        WARN,
        ACTIVE,
        COOLDOWN
    } state_t;

    state_t        state;
    logic [CW-1:0] cyc;
    logic [TW-1:0] tick;
    logic [SW-1:0] sp_cnt;

    logic          wrap;
    logic [CW-1:0] cyc_nxt;
    logic [TW-1:0] tick_nxt;
    logic [SW-1:0] sp_nxt;
    logic          sp_last;
    logic          warn_end;
    logic          act_end;
    logic          cd_end;
    logic [1:0]    pick;

`ifdef ATTACK_REPEAT_GUARD_EN
    logic [1:0] last_pat;
    logic       hist_vld;
`endif

    always_comb begin
        wrap     = (cyc == CW'(TICK_DIV - 1));
        cyc_nxt  = wrap ? '0 : cyc + 1'b1;
        tick_nxt = tick;
        if (wrap && tick != TW'(MAXT))
            tick_nxt = tick + 1'b1;
        sp_last  = (sp_cnt == SW'(SPAWN_PERIOD - 1));
        sp_nxt   = sp_cnt;
        if (wrap)
            sp_nxt = sp_last ? '0 : sp_cnt + 1'b1;
        // A zero-tick state still occupies one cycle
        warn_end = (WARN_TICKS == 0) ||
                   (wrap && tick == TW'(WARN_TICKS - 1));
        act_end  = (ATTACK_TICKS == 0) ||
                   (wrap && tick == TW'(ATTACK_TICKS - 1));
        cd_end   = (COOLDOWN_TICKS == 0) ||
                   (wrap && tick == TW'(COOLDOWN_TICKS - 1));
`ifdef ATTACK_REPEAT_GUARD_EN
        pick = (hist_vld && random_num == last_pat) ?
               random_num + 2'd1 : random_num;
`else
        pick = random_num;
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cyc        <= '0;
            tick       <= '0;
            sp_cnt     <= '0;
            pattern    <= '0;
            spawn_lane <= '0;
            warn       <= 1'b0;
            active     <= 1'b0;
            spawn      <= 1'b0;
            busy       <= 1'b0;
            turn_done  <= 1'b0;
`ifdef ATTACK_REPEAT_GUARD_EN
            last_pat   <= '0;
            hist_vld   <= 1'b0;
`endif
        end else begin
            spawn     <= 1'b0;
            turn_done <= 1'b0;
            if (state != IDLE && abort) begin
                state  <= IDLE;
                cyc    <= '0;
                tick   <= '0;
                sp_cnt <= '0;
                warn   <= 1'b0;
                active <= 1'b0;
                busy   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state <= PICK;
                            busy  <= 1'b1;
                        end
                    end
                    PICK: begin
                        pattern <= pick;
`ifdef ATTACK_REPEAT_GUARD_EN
                        last_pat <= pick;
                        hist_vld <= 1'b1;
`endif
                        cyc    <= '0;
                        tick   <= '0;
                        sp_cnt <= '0;
                        state  <= WARN;
                        warn   <= 1'b1;
                    end
                    WARN: begin
                        if (warn_end) begin
                            state  <= ACTIVE;
                            warn   <= 1'b0;
                            active <= 1'b1;
                            cyc    <= '0;
                            tick   <= '0;
                            sp_cnt <= '0;
                            // Tick 0 of ACTIVE always carries a spawn
                            if (ATTACK_TICKS > 0) begin
                                spawn      <= 1'b1;
                                spawn_lane <= random_num;
                            end
                        end else begin
                            cyc  <= cyc_nxt;
                            tick <= tick_nxt;
                        end
                    end
                    ACTIVE: begin
                        if (act_end) begin
                            state  <= COOLDOWN;
                            active <= 1'b0;
                            cyc    <= '0;
                            tick   <= '0;
                            sp_cnt <= '0;
                        end else begin
                            cyc    <= cyc_nxt;
                            tick   <= tick_nxt;
                            sp_cnt <= sp_nxt;
                            if (wrap && sp_last) begin
                                spawn      <= 1'b1;
                                spawn_lane <= random_num;
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (cd_end) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            turn_done <= 1'b1;
                            cyc       <= '0;
                            tick      <= '0;
                        end else begin
                            cyc  <= cyc_nxt;
                            tick <= tick_nxt;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_attack_pattern_scheduler.sv
// Directed bench for attack_pattern_scheduler with small timing parameters.
// Expects pattern 3 then 0 on repeated picks when ATTACK_REPEAT_GUARD_EN is set.
module tb_attack_pattern_scheduler;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] random_num;
    logic       start;
    logic       abort;
    logic [1:0] pattern;
    logic       warn;
    logic       active;
    logic       spawn;
    logic [1:0] spawn_lane;
    logic       busy;
    logic       turn_done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    attack_pattern_scheduler #(
        .TICK_DIV      (4),
        .WARN_TICKS    (2),
        .ATTACK_TICKS  (6),
        .SPAWN_PERIOD  (2),
        .COOLDOWN_TICKS(1)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .random_num(random_num),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .warn      (warn),
        .active    (active),
        .spawn     (spawn),
        .spawn_lane(spawn_lane),
        .busy      (busy),
        .turn_done (turn_done)
    );

    typedef struct {
        logic       st;
        logic       ab;
        logic [1:0] rnd;
        logic       busy;
        logic       warn;
        logic       act;
        logic       spw;
        logic       done;
        logic [1:0] pat;
        logic [1:0] lane;
        logic       chk_lane;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic st, input logic ab,
                       input logic [1:0] rnd, input logic b, input logic w,
                       input logic a, input logic s, input logic d,
                       input logic [1:0] p, input logic [1:0] l,
                       input logic cl);
        vec_t v;
        v.st = st; v.ab = ab; v.rnd = rnd;
        v.busy = b; v.warn = w; v.act = a; v.spw = s; v.done = d;
        v.pat = p; v.lane = l; v.chk_lane = cl;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run(input int n, output int sp, output int dn);
        sp = 0;
        dn = 0;
        repeat (n) begin
            @(negedge clk);
            sp += int'(spawn);
            dn += int'(turn_done);
        end
    endtask

    task automatic start_turn(input logic [1:0] r);
        start = 1'b1;
        random_num = r;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(busy), 0);
    endtask

    initial begin
        int sp;
        int dn;
        int tot;
        int bcnt;
        logic [1:0] exp_pat;

        // IDLE, PICK(rnd=2), 8 WARN, 24 ACTIVE, 4 COOLDOWN, done, idle
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1);
        add(4, 0, 0, 2, 1, 1, 0, 0, 0, 2, 0, 1);
        add(4, 0, 0, 1, 1, 1, 0, 0, 0, 2, 0, 1);
        add(1, 0, 0, 1, 1, 0, 1, 1, 0, 2, 0, 0);
        add(3, 0, 0, 1, 1, 0, 1, 0, 0, 2, 1, 1);
        add(4, 0, 0, 3, 1, 0, 1, 0, 0, 2, 1, 1);
        add(1, 0, 0, 3, 1, 0, 1, 1, 0, 2, 0, 0);
        add(3, 0, 0, 3, 1, 0, 1, 0, 0, 2, 3, 1);
        add(4, 0, 0, 2, 1, 0, 1, 0, 0, 2, 3, 1);
        add(1, 0, 0, 2, 1, 0, 1, 1, 0, 2, 0, 0);
        add(7, 0, 0, 2, 1, 0, 1, 0, 0, 2, 2, 1);
        add(4, 0, 0, 2, 1, 0, 0, 0, 0, 2, 2, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 1);

        resetn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        random_num = 2'd0;
        repeat (3) @(negedge clk);
        check("reset.outs",
              32'({pattern, warn, active, spawn, spawn_lane, busy, turn_done}), 0);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            check($sformatf("vec%0d.outs", i),
                  32'({busy, warn, active, spawn, turn_done, pattern}),
                  32'({tbl[i].busy, tbl[i].warn, tbl[i].act, tbl[i].spw,
                       tbl[i].done, tbl[i].pat}));
            if (tbl[i].chk_lane)
                check($sformatf("vec%0d.lane", i), 32'(spawn_lane),
                      32'(tbl[i].lane));
            start = tbl[i].st;
            abort = tbl[i].ab;
            random_num = tbl[i].rnd;
        end

        // Abort at active cycle 10
        start_turn(2'd1);
        check("abort.pattern", 32'(pattern), 1);
        run(7, sp, dn);
        @(negedge clk);
        check("abort.a0_spawn", 32'({active, spawn}), 3);
        run(10, sp, dn);
        check("abort.spawns_a1_a10", sp, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.outs", 32'({busy, warn, active, spawn, turn_done}), 0);
        check("abort.pat_held", 32'(pattern), 1);
        run(30, sp, dn);
        check("abort.after", 32'({sp[7:0], dn[7:0], 7'd0, busy}), 0);

        random_num = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart.pick", 32'({busy, warn}), 2);
        @(negedge clk);
        check("restart.warn", 32'({busy, warn}), 3);

        // Starts during WARN and ACTIVE are ignored
        tot = 0;
        start = 1'b1;
        run(1, sp, dn);
        tot += dn;
        start = 1'b0;
        run(12, sp, dn);
        tot += dn;
        check("ignore.in_active", 32'(active), 1);
        start = 1'b1;
        run(1, sp, dn);
        tot += dn;
        start = 1'b0;
        run(90, sp, dn);
        tot += dn;
        check("ignore.done_count", tot, 1);
        check("ignore.idle", 32'(busy), 0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("idle_sa.c1", 32'(busy), 0);
        @(negedge clk);
        check("idle_sa.c2", 32'(busy), 0);

        // Reset during WARN
        start_turn(2'd3);
        check("rst.pre_pat", 32'(pattern), 3);
        @(negedge clk);
        check("rst.pre_warn", 32'({busy, warn}), 3);
        #2 resetn = 1'b0;
        #1;
        check("rst.async",
              32'({pattern, warn, active, spawn, spawn_lane, busy, turn_done}), 0);
        @(negedge clk);
        resetn = 1'b1;
        bcnt = 0;
        repeat (50) begin
            @(negedge clk);
            bcnt += int'(busy);
        end
        check("rst.idle50", bcnt, 0);

        start_turn(2'd3);
        check("guard.first", 32'(pattern), 3);
        wait_idle("guard.first_idle");
        start_turn(2'd3);
`ifdef ATTACK_REPEAT_GUARD_EN
        exp_pat = 2'd0;
`else
        exp_pat = 2'd3;
`endif
        check("guard.second", 32'(pattern), 32'(exp_pat));
        wait_idle("guard.second_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/attack_pattern_scheduler.md
Name: attack_pattern_scheduler

Overview:
Downstream consumer of the 2-bit LFSR random output. It runs the enemy's turn in the bullet-box phase in four steps: pick one of four attack patterns, show a warning window, emit timed bullet-spawn pulses with random lanes, then cool down. The game-state FSM controls it with start/abort and receives a turn_done pulse. Its spawn outputs drive the bullet engine.

Parameters:
TICK_DIV, 833333, CLOCK_50 cycles per game tick (60 Hz at 50 MHz); must be >= 2
WARN_TICKS, 30, ticks spent in WARN
ATTACK_TICKS, 240, ticks spent in ACTIVE
SPAWN_PERIOD, 20, ticks between spawn pulses; must be >= 1
COOLDOWN_TICKS, 60, ticks spent in COOLDOWN

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
random_num  in  2  random value from the LFSR stage, new value every cycle
start  in  1  one-cycle request to begin an enemy turn
abort  in  1  cancel the turn (player death, menu)
pattern  out  2  selected attack pattern, valid from WARN onward
warn  out  1  high throughout WARN
active  out  1  high throughout ACTIVE
spawn  out  1  one-cycle bullet-spawn pulse
spawn_lane  out  2  lane for the latest spawn, held until the next spawn
busy  out  1  high in any state other than IDLE
turn_done  out  1  one-cycle pulse when COOLDOWN completes normally

Behaviour:
- Clock and reset: one clock domain (CLOCK_50). Reset is asynchronous and active-low on resetn.
- Reset values: state IDLE; pattern, spawn_lane, warn, active, spawn, busy and turn_done all 0; counters 0; history valid flag 0.
- States: IDLE, PICK, WARN, ACTIVE, COOLDOWN. All outputs are registered.
- IDLE:
  - start=1 and abort=0 moves to PICK.
  - start in any state other than IDLE is ignored; it is not queued.
- PICK: lasts exactly one cycle.
  - pattern <= random_num; the repeat guard may modify this (see Optional Feature).
  - Clears the cycle counter and tick counter, then moves to WARN.
- Timing:
  - The cycle counter counts 0..TICK_DIV-1 and wraps. Each wrap increments the tick counter.
  - On every state entry both counters are cleared. A state of N ticks therefore lasts exactly N*TICK_DIV cycles.
- WARN: warn=1. After WARN_TICKS ticks, moves to ACTIVE.
- ACTIVE:
  - active=1.
  - spawn=1 on the first cycle of every tick whose index k (0-based) satisfies k mod SPAWN_PERIOD == 0 and k < ATTACK_TICKS. The first spawn is on the first ACTIVE cycle.
  - In the same cycle, spawn_lane <= random_num.
  - Spawn count = ceil(ATTACK_TICKS/SPAWN_PERIOD); defaults give 12.
  - After ATTACK_TICKS ticks, moves to COOLDOWN.
- COOLDOWN:
  - After COOLDOWN_TICKS ticks, moves to IDLE.
  - turn_done=1 for the single cycle in which busy first reads 0.
- Zero-length states: a tick parameter of 0 makes that state last one cycle. ACTIVE with ATTACK_TICKS=0 emits no spawn.
- abort:
  - In any non-IDLE state: next state is IDLE, and warn, active and busy are 0 next cycle.
  - No turn_done and no spawn are emitted in that cycle or afterwards.
  - pattern and spawn_lane hold their values.
  - abort and start together in IDLE: stay IDLE.
- Reset mid-turn returns to reset values immediately; no turn_done is emitted.
- Widths: the cycle counter is ceil(log2(TICK_DIV)) bits. The tick counter is sized for the largest tick parameter and saturates at it; it never wraps.

Optional Feature:
Macro ATTACK_REPEAT_GUARD_EN.
- Defined:
  - The block stores the last chosen pattern and a valid flag, which is set at the first PICK after reset.
  - In PICK, if valid=1 and random_num equals the last pattern, pattern <= random_num+1 (mod 4). Otherwise pattern <= random_num.
  - Aborted turns still update the history.
- Undefined: pattern <= random_num unmodified, and no history registers exist.

Test Plan:
All scenarios use TICK_DIV=4, WARN_TICKS=2, ATTACK_TICKS=6, SPAWN_PERIOD=2, COOLDOWN_TICKS=1.
1. Reset check: assert resetn=0 mid-simulation -> all outputs 0 asynchronously. Release reset, hold start=0 for 50 cycles -> busy stays 0.
2. Full turn: start pulse with random_num=2 at PICK -> busy next cycle, pattern=2, warn high 8 cycles, then active high 24 cycles with spawns on active cycles 0, 8, 16 (3 pulses, spawn_lane = random_num sampled then), then cooldown 4 cycles, then turn_done one cycle with busy=0.
3. Abort at active cycle 10 -> IDLE next cycle; no third spawn and no turn_done; a new start then begins a fresh PICK.
4. start pulses during WARN and ACTIVE -> ignored; exactly one turn_done. start and abort together in IDLE -> stays IDLE.
5. Guard: two complete turns with random_num held at 3 -> macro defined: pattern 3 then 0; macro undefined: 3 then 3.
6. resetn low during WARN -> warn and busy drop immediately. After release, IDLE with history cleared: next turn with random_num=3 gives pattern 3 even with the guard defined.
